// File: rtl/seq_core_debug_mailbox_pkg.sv
// seq_core_debug_mailbox_pkg: shared state encoding, status layout and register offsets for the debug mailbox
package seq_core_debug_mailbox_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_BUSY    = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;
    localparam int STAT_STATE_LSB   = 0;
    localparam int STAT_OVERRUN_BIT = 3;
    localparam int STAT_RESULT_LSB  = 8;
    localparam logic [31:0] OFF_REQ    = 32'd0;
    localparam logic [31:0] OFF_STATUS = 32'd4;
    localparam logic [31:0] OFF_PARAMS = 32'd8;
    function automatic logic [31:0] status_word(state_t s, logic ovr, logic [23:0] res);
        logic [31:0] w;
        w = '0;
        w[STAT_STATE_LSB +: 3] = s;
        w[STAT_OVERRUN_BIT] = ovr;
        w[STAT_RESULT_LSB +: 24] = res;
        return w;
    endfunction
endpackage

// File: rtl/seq_core_debug_mailbox_regs.sv
// seq_core_debug_mailbox_regs: host address decode and fixed-latency read mux for the mailbox window
module seq_core_debug_mailbox_regs
    import seq_core_debug_mailbox_pkg::*;
#(
    parameter logic [31:0] CMD_BASE = 32'h000153BC,
    parameter int NUM_PARAMS = 4
) (
    input  logic                    avl_clk,
    input  logic                    avl_reset_n,
    input  logic [31:0]             avl_address,
    input  logic                    avl_read,
    input  logic                    avl_write,
    input  logic [31:0]             status,
    input  logic [31:0]             cmd_code,
    input  logic [32*NUM_PARAMS-1:0] params,
    output logic                    req_wr,
    output logic [NUM_PARAMS-1:0]   param_we,
    output logic [31:0]             avl_readdata,
    output logic                    avl_readdatavalid
);
    logic [31:0] bofs;
    logic [31:0] rd_mux;
    // addresses below the base wrap to huge offsets, so they never match a register
    assign bofs = (avl_address & ~32'h3) - (CMD_BASE & ~32'h3);
    assign req_wr = avl_write && bofs == OFF_REQ;
    always_comb begin
        param_we = '0;
        rd_mux = bofs == OFF_REQ ? cmd_code : bofs == OFF_STATUS ? status : '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            param_we[i] = avl_write && bofs == OFF_PARAMS + 32'(4 * i);
            if (bofs == OFF_PARAMS + 32'(4 * i)) rd_mux = params[32*i +: 32];
        end
    end
    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) begin
            avl_readdata <= '0;
            avl_readdatavalid <= 1'b0;
        end else begin
            avl_readdata <= avl_read ? rd_mux : '0;
            avl_readdatavalid <= avl_read;
        end
    end
endmodule

// File: rtl/seq_core_debug_mailbox.sv
// seq_core_debug_mailbox: host-to-sequencer command mailbox with status/overrun tracking.
// Define SEQ_CORE_DEBUG_MAILBOX_TIMEOUT_EN to add a BUSY timeout that ends in ERROR.
module seq_core_debug_mailbox
    import seq_core_debug_mailbox_pkg::*;
#(
    parameter logic [31:0] CMD_BASE = 32'h000153BC,
    parameter int NUM_PARAMS = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     avl_clk,
    input  logic                     avl_reset_n,
    input  logic [31:0]              avl_address,
    input  logic                     avl_read,
    input  logic                     avl_write,
    input  logic [31:0]              avl_writedata,
    output logic [31:0]              avl_readdata,
    output logic                     avl_readdatavalid,
    output logic                     avl_waitrequest,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [31:0]              cmd_code,
    output logic [32*NUM_PARAMS-1:0] cmd_params,
    input  logic                     rsp_valid,
    input  logic [23:0]              rsp_result
);
    state_t state, state_n;
    logic req_wr, open, timeout, overrun;
    logic [NUM_PARAMS-1:0] param_we;
    logic [23:0] result;
    logic [32*NUM_PARAMS-1:0] params;
    seq_core_debug_mailbox_regs #(.CMD_BASE(CMD_BASE), .NUM_PARAMS(NUM_PARAMS)) u_regs (
        .avl_clk(avl_clk),
        .avl_reset_n(avl_reset_n),
        .avl_address(avl_address),
        .avl_read(avl_read),
        .avl_write(avl_write),
        .status(status_word(state, overrun, result)),
        .cmd_code(cmd_code),
        .params(params),
        .req_wr(req_wr),
        .param_we(param_we),
        .avl_readdata(avl_readdata),
        .avl_readdatavalid(avl_readdatavalid)
    );
    assign avl_waitrequest = 1'b0;
    assign cmd_params = params;
    assign open = state != ST_PENDING && state != ST_BUSY;
`ifdef SEQ_CORE_DEBUG_MAILBOX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] busy_cnt;
    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) busy_cnt <= '0;
        else busy_cnt <= state == ST_BUSY ? busy_cnt + 1'b1 : '0;
    end
    assign timeout = state == ST_BUSY && busy_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = TIMEOUT_CYCLES < 0;
`endif
    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) state <= ST_IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (req_wr && |avl_writedata) state_n = ST_PENDING;
            ST_PENDING: if (cmd_ready) state_n = ST_BUSY;
            ST_BUSY:    state_n = rsp_valid ? ST_DONE : timeout ? ST_ERROR : ST_BUSY;
            default:    if (req_wr) state_n = |avl_writedata ? ST_PENDING : ST_IDLE;
        endcase
    end
    always_comb cmd_valid = state == ST_PENDING;
    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) begin
            cmd_code <= '0;
            params <= '0;
            result <= '0;
            overrun <= 1'b0;
        end else begin
            if (req_wr && open && |avl_writedata) cmd_code <= avl_writedata;
            for (int i = 0; i < NUM_PARAMS; i++)
                if (param_we[i] && open) params[32*i +: 32] <= avl_writedata;
            // a response beats a colliding host write; the write then only flags overrun
            if (state == ST_BUSY && rsp_valid) result <= rsp_result;
            else if (timeout) result <= 24'hFFFFFF;
            else if (req_wr && open) result <= '0;
            if ((req_wr || |param_we) && !open) overrun <= 1'b1;
            else if (req_wr && open && avl_writedata == '0) overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_core_debug_mailbox.sv
// tb_seq_core_debug_mailbox: directed table, corner sequences and randomized model check of the mailbox
module tb_seq_core_debug_mailbox;
    localparam logic [31:0] BASE = 32'h000153BC;
    localparam int NP = 4;
`ifdef SEQ_CORE_DEBUG_MAILBOX_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 0;
`endif
    logic clk = 0, rst_n = 0;
    logic [31:0] avl_address = 0, avl_writedata = 0, avl_readdata, cmd_code;
    logic avl_read = 0, avl_write = 0, avl_readdatavalid, avl_waitrequest;
    logic cmd_valid, cmd_ready = 0, rsp_valid = 0;
    logic [23:0] rsp_result = 0;
    logic [32*NP-1:0] cmd_params;
    int errors = 0, checks = 0;

    seq_core_debug_mailbox #(.CMD_BASE(BASE), .NUM_PARAMS(NP), .TIMEOUT_CYCLES(8)) dut (
        .avl_clk(clk), .avl_reset_n(rst_n), .avl_address(avl_address), .avl_read(avl_read),
        .avl_write(avl_write), .avl_writedata(avl_writedata), .avl_readdata(avl_readdata),
        .avl_readdatavalid(avl_readdatavalid), .avl_waitrequest(avl_waitrequest),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_params(cmd_params),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  off;
        logic [31:0] data;
        logic        ready;
        logic        rsp;
        logic [23:0] res;
        logic [31:0] exp_status;
        logic        exp_valid;
        logic [31:0] exp_code;
    } row_t;
    row_t rows [16];

    int m_state, m_busy;
    logic m_ovr;
    logic [23:0] m_result;
    logic [31:0] m_code;
    logic [31:0] m_params [NP];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        avl_read = 0; avl_write = 0; cmd_ready = 0; rsp_valid = 0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        avl_write = 1; avl_address = addr; avl_writedata = data;
        tick();
        avl_write = 0;
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        avl_read = 1; avl_address = addr;
        tick();
        avl_read = 0;
        chk({name, "_valid"}, 32'(avl_readdatavalid), 32'd1);
        chk(name, avl_readdata, exp);
    endtask

    function automatic logic [31:0] m_status();
        return {m_result, 4'b0, m_ovr, 3'(m_state)};
    endfunction

    task automatic m_reset();
        m_state = 0; m_busy = 0; m_ovr = 0; m_result = 0; m_code = 0;
        for (int i = 0; i < NP; i++) m_params[i] = 0;
    endtask

    // one clock of mailbox behaviour: states 0 idle,1 pending,2 busy,3 done,4 error
    task automatic m_step(input bit wreq, input int pw, input logic [31:0] d, input bit rsp,
                          input logic [23:0] res, input bit rdy);
        bit busy;
        busy = m_state == 1 || m_state == 2;
        if ((wreq || pw >= 0) && busy) m_ovr = 1;
        if (!busy && pw >= 0) m_params[pw] = d;
        if (!busy && wreq && d == 0) m_ovr = 0;
        if (m_state == 0) begin
            if (wreq && d != 0) begin m_code = d; m_state = 1; end
        end else if (m_state == 1) begin
            if (rdy) begin m_state = 2; m_busy = 0; end
        end else if (m_state == 2) begin
            if (rsp) begin m_state = 3; m_result = res; end
            else begin
                m_busy++;
                if (TO > 0 && m_busy == TO) begin m_state = 4; m_result = 24'hFFFFFF; end
            end
        end else if (wreq) begin
            m_result = 0;
            if (d == 0) m_state = 0;
            else begin m_code = d; m_state = 1; end
        end
    endtask

    initial begin
        rows[0]  = '{1'b1, 8'h08, 32'h11,  1'b0, 1'b0, 24'h0,      32'h0,        1'b0, 32'h0};
        rows[1]  = '{1'b1, 8'h00, 32'h5,   1'b0, 1'b0, 24'h0,      32'h1,        1'b1, 32'h5};
        rows[2]  = '{1'b0, 8'h00, 32'h0,   1'b1, 1'b0, 24'h0,      32'h2,        1'b0, 32'h5};
        rows[3]  = '{1'b0, 8'h00, 32'h0,   1'b0, 1'b1, 24'hABCDE,  32'h0ABCDE03, 1'b0, 32'h5};
        rows[4]  = '{1'b1, 8'h00, 32'h0,   1'b0, 1'b0, 24'h0,      32'h0,        1'b0, 32'h5};
        rows[5]  = '{1'b1, 8'h00, 32'h0,   1'b0, 1'b0, 24'h0,      32'h0,        1'b0, 32'h5};
        rows[6]  = '{1'b1, 8'h00, 32'h5,   1'b0, 1'b0, 24'h0,      32'h1,        1'b1, 32'h5};
        rows[7]  = '{1'b1, 8'h00, 32'h9,   1'b0, 1'b0, 24'h0,      32'h9,        1'b1, 32'h5};
        rows[8]  = '{1'b1, 8'h0C, 32'h22,  1'b0, 1'b0, 24'h0,      32'h9,        1'b1, 32'h5};
        rows[9]  = '{1'b0, 8'h00, 32'h0,   1'b1, 1'b0, 24'h0,      32'hA,        1'b0, 32'h5};
        rows[10] = '{1'b1, 8'h00, 32'h7,   1'b0, 1'b1, 24'h123,    32'h0001230B, 1'b0, 32'h5};
        rows[11] = '{1'b1, 8'h00, 32'h33,  1'b0, 1'b0, 24'h0,      32'h9,        1'b1, 32'h33};
        rows[12] = '{1'b0, 8'h00, 32'h0,   1'b1, 1'b0, 24'h0,      32'hA,        1'b0, 32'h33};
        rows[13] = '{1'b0, 8'h00, 32'h0,   1'b0, 1'b1, 24'hFFFFFF, 32'hFFFFFF0B, 1'b0, 32'h33};
        rows[14] = '{1'b1, 8'h00, 32'h0,   1'b0, 1'b0, 24'h0,      32'h0,        1'b0, 32'h33};
        rows[15] = '{1'b0, 8'h00, 32'h0,   1'b0, 1'b1, 24'h55,     32'h0,        1'b0, 32'h33};

        repeat (3) @(negedge clk);
        chk("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("reset_rdvalid", 32'(avl_readdatavalid), 32'd0);
        chk("waitrequest", 32'(avl_waitrequest), 32'd0);
        rst_n = 1;
        tick();
        rd("reset_status", BASE + 4, 32'h0);

        for (int i = 0; i < $size(rows); i++) begin
            avl_write = rows[i].wr; avl_address = BASE + 32'(rows[i].off); avl_writedata = rows[i].data;
            cmd_ready = rows[i].ready; rsp_valid = rows[i].rsp; rsp_result = rows[i].res;
            tick();
            quiet();
            chk($sformatf("row%0d_cmd_valid", i), 32'(cmd_valid), 32'(rows[i].exp_valid));
            chk($sformatf("row%0d_cmd_code", i), cmd_code, rows[i].exp_code);
            if (i == 1) chk("row1_param0", cmd_params[31:0], 32'h11);
            rd($sformatf("row%0d_status", i), BASE + 4, rows[i].exp_status);
        end

        rd("param0", BASE + 8, 32'h11);
        rd("param1_discarded", BASE + 32'hC, 32'h0);
        wr(BASE + 32'h16, 32'h44);
        rd("param3_lowbits", BASE + 32'h14, 32'h44);
        chk("cmd_params3", cmd_params[127:96], 32'h44);
        wr(BASE + 32'h18, 32'hDEAD);
        wr(BASE - 4, 32'hBEEF);
        rd("past_window", BASE + 32'h18, 32'h0);
        rd("below_window", BASE - 4, 32'h0);
        rd("status_after_outside_wr", BASE + 4, 32'h0);

        wr(BASE, 32'h1);
        cmd_ready = 1; tick(); cmd_ready = 0;
        rd("busy_status", BASE + 4, 32'h2);
`ifdef SEQ_CORE_DEBUG_MAILBOX_TIMEOUT_EN
        repeat (20) tick();
        rd("timeout_status", BASE + 4, 32'hFFFFFF04);
        wr(BASE, 32'h0);
        rd("timeout_cleared", BASE + 4, 32'h0);
`else
        repeat (1000) tick();
        rd("no_timeout_status", BASE + 4, 32'h2);
        rsp_valid = 1; rsp_result = 24'h1; tick(); rsp_valid = 0;
        wr(BASE, 32'h0);
`endif

        wr(BASE, 32'h3);
        cmd_ready = 1; tick(); cmd_ready = 0;
        avl_read = 1; avl_address = BASE + 4;
        tick();
        rst_n = 0;
        #1;
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_rdvalid", 32'(avl_readdatavalid), 32'd0);
        chk("rst_rddata", avl_readdata, 32'h0);
        quiet();
        tick();
        rst_n = 1;
        tick();
        rd("post_rst_status", BASE + 4, 32'h0);
        rd("post_rst_param0", BASE + 8, 32'h0);
        chk("post_rst_cmd_code", cmd_code, 32'h0);

        m_reset();
        begin
            bit pend;
            logic [31:0] exp_rd;
            pend = 0; exp_rd = 0;
            for (int n = 0; n < 3000; n++) begin
                bit wreq;
                int pw, op, k;
                wreq = 0; pw = -1;
                avl_write = 0; avl_read = 0;
                avl_address = $urandom; avl_writedata = $urandom;
                cmd_ready = 1'($urandom_range(0, 1));
                rsp_valid = $urandom_range(0, 7) == 0;
                rsp_result = 24'($urandom);
                op = $urandom_range(0, 7);
                if (op == 0) begin
                    avl_write = 1; wreq = 1;
                    avl_address = BASE + 32'($urandom_range(0, 3));
                    avl_writedata = $urandom_range(0, 2) == 0 ? 32'h0 : ($urandom | 32'h1);
                end else if (op == 1) begin
                    pw = $urandom_range(0, NP - 1);
                    avl_write = 1;
                    avl_address = BASE + 32'(8 + 4 * pw + $urandom_range(0, 3));
                end else if (op == 2) begin
                    avl_write = 1;
                    avl_address = $urandom_range(0, 1) ? BASE + 32'(24 + 4 * $urandom_range(0, 100))
                                                        : BASE - 32'(4 * $urandom_range(1, 100));
                end else if (op <= 4) begin
                    avl_read = 1;
                    k = $urandom_range(0, NP + 1);
                    if (k == 0) begin
                        avl_address = BASE + 32'(24 + 4 * $urandom_range(0, 100));
                        exp_rd = 0;
                    end else if (k == 1) begin
                        avl_address = BASE + 4 + 32'($urandom_range(0, 3));
                        exp_rd = m_status();
                    end else begin
                        avl_address = BASE + 32'(8 + 4 * (k - 2) + $urandom_range(0, 3));
                        exp_rd = m_params[k-2];
                    end
                end
                pend = avl_read;
                m_step(wreq, pw, avl_writedata, rsp_valid, rsp_result, cmd_ready);
                tick();
                chk("rnd_rdvalid", 32'(avl_readdatavalid), 32'(pend));
                if (pend) chk("rnd_readdata", avl_readdata, exp_rd);
                chk("rnd_cmd_valid", 32'(cmd_valid), 32'(m_state == 1));
                chk("rnd_cmd_code", cmd_code, m_code);
                for (int i = 0; i < NP; i++) chk("rnd_cmd_params", cmd_params[32*i +: 32], m_params[i]);
            end
        end
        quiet();
        tick();
        avl_read = 1; avl_address = BASE + 4;
        begin
            logic [31:0] fin;
            fin = m_status();
            tick();
            avl_read = 0;
            chk("final_status", avl_readdata, fin);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_core_debug_mailbox.md
SEQ_CORE_DEBUG_MAILBOX -- requirements
Module: seq_core_debug_mailbox

Interface
REQ-001 SHALL have parameter CMD_BASE, default 'h000153BC, byte address of the command request word.
REQ-002 SHALL have parameter NUM_PARAMS, default 4, number of 32-bit parameter words (range 1..16).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, busy timeout (used only with the REQ-028 macro).
REQ-004 avl_clk  input  1  single clock for all logic.
REQ-005 avl_reset_n  input  1  asynchronous, active-low reset.
REQ-006 avl_address  input  32  host byte address.
REQ-007 avl_read / avl_write  input  1 each  host read/write strobes (never both high).
REQ-008 avl_writedata  input  32  host write data.
REQ-009 avl_readdata  output  32  read data; avl_readdatavalid  output  1  read-data qualifier.
REQ-010 avl_waitrequest  output  1  tied 0.
REQ-011 cmd_valid  output  1  command offered to the sequencer; cmd_ready  input  1  sequencer accepts.
REQ-012 cmd_code  output  32  latched request word; cmd_params  output  32*NUM_PARAMS  parameter words, word 0 in LSBs.
REQ-013 rsp_valid  input  1  one-cycle completion pulse; rsp_result  input  24  result value.

Function
REQ-014 Register map SHALL be: REQ_CMD at CMD_BASE+0, CMD_STATUS at +4, PARAM[i] at +8+4*i; addresses are word-aligned (bits [1:0] ignored).
REQ-015 Reads SHALL have fixed latency 1: avl_readdatavalid high exactly one cycle after avl_read, with avl_readdata valid in that cycle.
REQ-016 Reads inside the window but unmapped, and all reads outside it, SHALL return 0; writes outside the window SHALL be ignored.
REQ-017 CMD_STATUS SHALL read as {result[23:0], 4'b0, overrun, state[2:0]}; state codes IDLE=0, PENDING=1, BUSY=2, DONE=3, ERROR=4.
REQ-018 FSM SHALL transition IDLE->PENDING on a REQ_CMD write with nonzero data, latching the data into cmd_code.
REQ-019 In PENDING, cmd_valid SHALL be 1 and cmd_code/cmd_params SHALL be stable; PENDING->BUSY in the cycle after cmd_valid&&cmd_ready.
REQ-020 BUSY->DONE on rsp_valid, capturing rsp_result into result; rsp_valid in any other state SHALL be ignored.
REQ-021 DONE or ERROR->IDLE on a REQ_CMD write of 0; a nonzero write in DONE/ERROR SHALL start a new command directly (->PENDING) and clear result.
REQ-022 A REQ_CMD write of 0 in IDLE SHALL be a no-op.
REQ-023 Any REQ_CMD write in PENDING or BUSY SHALL be discarded and set the sticky overrun bit; overrun clears only on a write of 0 to REQ_CMD in IDLE/DONE/ERROR, or reset.
REQ-024 PARAM writes SHALL take effect only in IDLE, DONE or ERROR; in PENDING/BUSY they SHALL be discarded and set overrun.
REQ-025 Simultaneous rsp_valid and host REQ_CMD write in BUSY: response SHALL win (->DONE), write discarded with overrun set.
REQ-026 A host read of CMD_STATUS in the transition cycle SHALL return the pre-transition state.

Reset
REQ-027 On avl_reset_n low, regardless of state: state=IDLE, cmd_valid=0, cmd_code=0, all params=0, result=0, overrun=0, avl_readdatavalid=0, avl_readdata=0; an in-flight command SHALL be abandoned without a response.

Configuration
REQ-028 With SEQ_CORE_DEBUG_MAILBOX_TIMEOUT_EN defined, a counter SHALL start at 0 on entry to BUSY and, after TIMEOUT_CYCLES cycles without rsp_valid, force BUSY->ERROR with result=24'hFFFFFF; rsp_valid on the expiry cycle SHALL win (->DONE).
REQ-029 Without SEQ_CORE_DEBUG_MAILBOX_TIMEOUT_EN, no counter SHALL exist, BUSY SHALL wait indefinitely, and ERROR SHALL be unreachable.

Structure
REQ-030 A shared package seq_core_debug_mailbox_pkg SHALL hold the state enum, status bit positions, and register offsets (REQ 0, STATUS 4, PARAMS 8).
REQ-031 A single sub-module seq_core_debug_mailbox_regs SHALL implement the address decode and read mux; the FSM SHALL live in the top.

Verification
REQ-032 Write PARAM0='h11, REQ_CMD='h5, cmd_ready=1 -> cmd_valid one cycle, cmd_code='h5, cmd_params[31:0]='h11; STATUS reads 2.
REQ-033 In BUSY pulse rsp_valid with rsp_result='hABCDE -> STATUS='h0ABCDE03; then write REQ_CMD=0 -> STATUS=0.
REQ-034 In PENDING (cmd_ready=0) write REQ_CMD='h9 and PARAM1='h22 -> cmd_code stays 'h5, PARAM1 unchanged, STATUS bit 3 set.
REQ-035 Same-cycle rsp_valid and REQ_CMD write in BUSY -> state DONE, overrun=1, cmd_code unchanged.
REQ-036 With macro, TIMEOUT_CYCLES=8, no rsp_valid -> STATUS='hFFFFFF04 after 8 BUSY cycles; without macro, still 2 after 1000 cycles.
REQ-037 Assert avl_reset_n=0 during BUSY -> next read of STATUS returns 0, cmd_valid=0.
